// File: rtl/b3_counter_pkg.sv
// Shared base-3 digit definitions for the ternary counter and its digit cells.
// Encoding: 00=0, 01=1, 10=2, 11=illegal.
package b3_counter_pkg;

   localparam logic [1:0] B3_D0   = 2'b00;
   localparam logic [1:0] B3_D1   = 2'b01;
   localparam logic [1:0] B3_D2   = 2'b10;
   localparam logic [1:0] B3_DINV = 2'b11;

   function automatic logic b3_legal(input logic [1:0] d);
      return (d != B3_DINV);
   endfunction

endpackage

// File: rtl/b3_halfadder.sv
// Single base-3 digit half adder: s = (a + cin) mod 3, cout on 2 + 1.
// An illegal input digit produces digit 0 with no carry.
module b3_halfadder
   import b3_counter_pkg::*;
(
   input  logic [1:0] a,
   input  logic       cin,
   output logic [1:0] s,
   output logic       cout
);

   always_comb begin
      s    = a;
      cout = 1'b0;
      if (!b3_legal(a)) begin
         s = B3_D0;
      end else if (cin) begin
         case (a)
            B3_D0:   s = B3_D1;
            B3_D1:   s = B3_D2;
            default: begin
               s    = B3_D0;
               cout = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/b3_counter.sv
// N-digit base-3 up-counter built from a ripple chain of b3_halfadder cells,
// with parallel load, sticky overflow and rejection of illegal load values.
module b3_counter
   import b3_counter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clock,
   input  logic           reset_,
   input  logic           en,
   input  logic           load,
   input  logic [2*N-1:0] din,
   output logic [2*N-1:0] q,
   output logic           cout,
   output logic           ovf,
   output logic           err,
   output logic           tc
);

   logic [2*N-1:0] q_q, q_d, sum;
   logic           cout_q, cout_d;
   logic           ovf_q, ovf_d;
   logic           err_q, err_d;
   logic [N:0]     carry;
   logic           din_ok;

   // Increment ripple: LSD always sees cin=1, each digit carries into the next.
   assign carry[0] = 1'b1;

   for (genvar g = 0; g < N; g++) begin : g_digit
      b3_halfadder u_ha (
         .a    (q_q[2*g +: 2]),
         .cin  (carry[g]),
         .s    (sum[2*g +: 2]),
         .cout (carry[g+1])
      );
   end

   always_comb begin
      din_ok = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (!b3_legal(din[2*i +: 2])) din_ok = 1'b0;
      end
   end

   always_comb begin
      tc = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (q_q[2*i +: 2] != B3_D2) tc = 1'b0;
      end
   end

   // Priority: load > en > hold; reset is applied in the register block.
   always_comb begin
      q_d    = q_q;
      ovf_d  = ovf_q;
      cout_d = 1'b0;
      err_d  = 1'b0;
      if (load) begin
         if (din_ok) begin
            q_d   = din;
            ovf_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end else if (en) begin
         q_d    = sum;
         cout_d = carry[N];
         if (carry[N]) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_) begin
         q_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         err_q  <= err_d;
      end
   end

   assign q    = q_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign err  = err_q;

endmodule
